// File: rtl/cp0_exception_pkg.sv
// rtl/cp0_exception_pkg.sv - ExcCodes, CP0 register numbers and field positions
package cp0_exception_pkg;

  // ExcCode values written into Cause[6:2]
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // CP0 register numbers used by mtc0/mfc0
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Status field positions
  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;

  // Cause field positions; IP[7:2] are the hardware lines at bits 15:10
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_IPHW_LSB = 10;
  localparam int CAUSE_BD      = 31;

  // BEV=1, everything else clear
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

endpackage

// File: rtl/cp0_exception_if.sv
// rtl/cp0_exception_if.sv - M-stage exception flags and CP0 access bus
interface cp0_exception_if;
  logic        stallM;
  logic [31:0] pcM;
  logic        is_in_delayslotM;
  logic        riM;
  logic        breakM;
  logic        syscallM;
  logic        eretM;
  logic        overflowM;
  logic        adel_ifM;
  logic        adel_ldM;
  logic        ades_stM;
  logic [31:0] bad_addrM;
  logic        cp0_wenM;
  logic [4:0]  cp0_waddrM;
  logic [31:0] cp0_wdataM;
  logic [4:0]  cp0_raddrM;
  logic [31:0] cp0_rdataM;

  modport master (
    output stallM, pcM, is_in_delayslotM, riM, breakM, syscallM, eretM,
           overflowM, adel_ifM, adel_ldM, ades_stM, bad_addrM,
           cp0_wenM, cp0_waddrM, cp0_wdataM, cp0_raddrM,
    input  cp0_rdataM
  );

  modport slave (
    input  stallM, pcM, is_in_delayslotM, riM, breakM, syscallM, eretM,
           overflowM, adel_ifM, adel_ldM, ades_stM, bad_addrM,
           cp0_wenM, cp0_waddrM, cp0_wdataM, cp0_raddrM,
    output cp0_rdataM
  );
endinterface

// File: rtl/cp0_exception_exc_prio.sv
// rtl/cp0_exception_exc_prio.sv - fixed-priority exception selector
module exc_prio
  import cp0_exception_pkg::*;
(
  input  logic       int_pend_i,
  input  logic       adel_if_i,
  input  logic       ri_i,
  input  logic       break_i,
  input  logic       syscall_i,
  input  logic       overflow_i,
  input  logic       adel_ld_i,
  input  logic       ades_st_i,
  input  logic       eret_i,
  output logic       exc_valid_o,
  output logic [4:0] exc_code_o,
  output logic       is_eret_o
);

  // First set flag in priority order wins; eret only counts when nothing else fires
  always_comb begin
    exc_valid_o = 1'b1;
    exc_code_o  = EXC_INT;
    if (int_pend_i)      exc_code_o = EXC_INT;
    else if (adel_if_i)  exc_code_o = EXC_ADEL;
    else if (ri_i)       exc_code_o = EXC_RI;
    else if (break_i)    exc_code_o = EXC_BP;
    else if (syscall_i)  exc_code_o = EXC_SYS;
    else if (overflow_i) exc_code_o = EXC_OV;
    else if (adel_ld_i)  exc_code_o = EXC_ADEL;
    else if (ades_st_i)  exc_code_o = EXC_ADES;
    else                 exc_valid_o = 1'b0;
    is_eret_o = eret_i & ~exc_valid_o;
  end

endmodule

// File: rtl/cp0_exception.sv
// rtl/cp0_exception.sv - CP0 register file, exception commit and Count/Compare timer
module cp0_exception
  import cp0_exception_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY      = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV_LOG2 = 1
) (
  input  logic           clk,
  input  logic           resetn,
  cp0_exception_if.slave m,
  input  logic [5:0]     ext_int,
  output logic           flush_exc,
  output logic [31:0]    pc_exc,
  output logic [31:0]    epc_o,
  output logic [31:0]    status_o,
  output logic [31:0]    cause_o
);

  localparam int unsigned DIV_W = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((33'd1 << COUNT_DIV_LOG2) - 33'd1);

  logic [31:0]      badvaddr_q, badvaddr_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic [31:0]      status_q, status_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ti_q, ti_d;

  logic       int_pend;
  logic       exc_valid;
  logic       is_eret;
  logic [4:0] exc_code;
  logic       wr_en;
  logic       tick;

  assign int_pend = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                  & (|(cause_q[CAUSE_IP_LSB +: 8] & status_q[STATUS_IM_LSB +: 8]));

  exc_prio u_exc_prio (
    .int_pend_i  (int_pend),
    .adel_if_i   (m.adel_ifM),
    .ri_i        (m.riM),
    .break_i     (m.breakM),
    .syscall_i   (m.syscallM),
    .overflow_i  (m.overflowM),
    .adel_ld_i   (m.adel_ldM),
    .ades_st_i   (m.ades_stM),
    .eret_i      (m.eretM),
    .exc_valid_o (exc_valid),
    .exc_code_o  (exc_code),
    .is_eret_o   (is_eret)
  );

  // An exception in the same cycle wins over mtc0, so the write is dropped when flushing
  assign flush_exc = resetn & ~m.stallM & (exc_valid | is_eret);
  assign pc_exc    = is_eret ? epc_q : EXC_ENTRY;
  assign wr_en     = m.cp0_wenM & ~m.stallM & ~flush_exc;
  assign tick      = (div_q == DIV_MAX);

  assign epc_o    = epc_q;
  assign status_o = status_q;
  assign cause_o  = cause_q;

  // mfc0 read mux over pre-edge register values
  always_comb begin
    m.cp0_rdataM = 32'd0;
    case (m.cp0_raddrM)
      CP0_BADVADDR: m.cp0_rdataM = badvaddr_q;
      CP0_COUNT:    m.cp0_rdataM = count_q;
      CP0_COMPARE:  m.cp0_rdataM = compare_q;
      CP0_STATUS:   m.cp0_rdataM = status_q;
      CP0_CAUSE:    m.cp0_rdataM = cause_q;
      CP0_EPC:      m.cp0_rdataM = epc_q;
      default:      m.cp0_rdataM = 32'd0;
    endcase
  end

  // Next-state: timer, hardware IP refresh, mtc0 writes, then exception/eret commit
  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    count_d    = tick ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    ti_d       = ti_q | (count_q == compare_q);
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    cause_d[CAUSE_IPHW_LSB +: 6] = {ext_int[5] | ti_q, ext_int[4:0]};

    if (wr_en) begin
      case (m.cp0_waddrM)
        CP0_COUNT: begin
          count_d = m.cp0_wdataM;
          div_d   = '0;
        end
        CP0_COMPARE: begin
          compare_d = m.cp0_wdataM;
          ti_d      = 1'b0;
        end
        CP0_STATUS: begin
          status_d[STATUS_IM_LSB +: 8] = m.cp0_wdataM[STATUS_IM_LSB +: 8];
          status_d[STATUS_EXL]         = m.cp0_wdataM[STATUS_EXL];
          status_d[STATUS_IE]          = m.cp0_wdataM[STATUS_IE];
        end
        CP0_CAUSE: cause_d[CAUSE_IP_LSB +: 2] = m.cp0_wdataM[CAUSE_IP_LSB +: 2];
        CP0_EPC:   epc_d = m.cp0_wdataM;
        default: ;
      endcase
    end

    if (flush_exc && exc_valid) begin
      // Nested exceptions keep the original return point
      if (!status_q[STATUS_EXL]) begin
        epc_d           = m.is_in_delayslotM ? m.pcM - 32'd4 : m.pcM;
        cause_d[CAUSE_BD] = m.is_in_delayslotM;
      end
      status_d[STATUS_EXL]          = 1'b1;
      cause_d[CAUSE_EXC_LSB +: 5]   = exc_code;
      if (!int_pend && m.adel_ifM) begin
        badvaddr_d = m.pcM;
      end else if (exc_code == EXC_ADEL || exc_code == EXC_ADES) begin
        badvaddr_d = m.bad_addrM;
      end
    end else if (flush_exc && is_eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      div_q      <= '0;
      ti_q       <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      div_q      <= div_d;
      ti_q       <= ti_d;
    end
  end

endmodule

// File: tb/tb_cp0_exception.sv
// tb/tb_cp0_exception.sv - self-checking bench for cp0_exception
module tb_cp0_exception;

  localparam logic [31:0] ENTRY = 32'hBFC0_0380;
  localparam int          DIV   = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  ext_int;
  logic        flush_exc;
  logic [31:0] pc_exc, epc_o, status_o, cause_o;

  int vectors = 0;
  int miscompares = 0;

  cp0_exception_if bus();

  cp0_exception #(.EXC_ENTRY(ENTRY), .COUNT_DIV_LOG2(1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m         (bus),
    .ext_int   (ext_int),
    .flush_exc (flush_exc),
    .pc_exc    (pc_exc),
    .epc_o     (epc_o),
    .status_o  (status_o),
    .cause_o   (cause_o)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as architectural fields
  logic [7:0]  m_im, m_ip;
  logic        m_ie, m_exl, m_bd, m_ti;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_badv, m_count, m_compare;
  int          m_phase;
  int          exc_tbl [8] = '{0, 4, 10, 9, 8, 12, 4, 5};

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, 15'd0, m_ip, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic m_intp();
    return m_ie && !m_exl && ((m_ip & m_im) != 8'd0);
  endfunction

  function automatic int m_exc_idx();
    logic [7:0] f;
    f = {bus.ades_stM, bus.adel_ldM, bus.overflowM, bus.syscallM,
         bus.breakM, bus.riM, bus.adel_ifM, m_intp()};
    for (int i = 0; i < 8; i++) if (f[i]) return i;
    return -1;
  endfunction

  function automatic logic m_flush();
    return resetn && !bus.stallM && (m_exc_idx() >= 0 || bus.eretM);
  endfunction

  function automatic logic [31:0] m_pc();
    return (m_exc_idx() < 0 && bus.eretM) ? m_epc : ENTRY;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status();
      5'd13: return m_cause();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clock();
    int idx;
    logic fl, wr, old_ti, eq, inc;
    logic [4:0] wa;
    logic [31:0] wd;
    if (!resetn) begin
      m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ip = 0; m_code = 0; m_ti = 0;
      m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0; m_phase = 0;
      return;
    end
    idx = m_exc_idx();
    fl  = m_flush();
    wa  = bus.cp0_waddrM;
    wd  = bus.cp0_wdataM;
    wr  = bus.cp0_wenM && !bus.stallM && !fl;
    old_ti = m_ti;
    eq  = (m_count == m_compare);
    inc = (m_phase == DIV - 1);
    m_phase = (m_phase + 1) % DIV;
    m_ti = (wr && wa == 5'd11) ? 1'b0 : (m_ti | eq);
    if (wr && wa == 5'd9) begin
      m_count = wd;
      m_phase = 0;
    end else if (inc) begin
      m_count = m_count + 1;
    end
    if (wr && wa == 5'd11) m_compare = wd;
    m_ip[7:2] = {ext_int[5] | old_ti, ext_int[4:0]};
    if (wr && wa == 5'd12) begin
      m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0];
    end
    if (wr && wa == 5'd13) m_ip[1:0] = wd[9:8];
    if (wr && wa == 5'd14) m_epc = wd;
    if (fl && idx >= 0) begin
      if (!m_exl) begin
        m_epc = bus.is_in_delayslotM ? bus.pcM - 4 : bus.pcM;
        m_bd  = bus.is_in_delayslotM;
      end
      m_exl  = 1'b1;
      m_code = exc_tbl[idx][4:0];
      if (idx == 1) m_badv = bus.pcM;
      else if (idx == 6 || idx == 7) m_badv = bus.bad_addrM;
    end else if (fl) begin
      m_exl = 1'b0;
    end
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stallM = 0; bus.is_in_delayslotM = 0;
    bus.riM = 0; bus.breakM = 0; bus.syscallM = 0; bus.eretM = 0;
    bus.overflowM = 0; bus.adel_ifM = 0; bus.adel_ldM = 0; bus.ades_stM = 0;
    bus.bad_addrM = 0; bus.cp0_wenM = 0; bus.cp0_waddrM = 0; bus.cp0_wdataM = 0;
    bus.cp0_raddrM = 0; ext_int = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_wenM = 1; bus.cp0_waddrM = a; bus.cp0_wdataM = d;
    cyc();
    bus.cp0_wenM = 0;
  endtask

  task automatic do_eret();
    idle();
    bus.eretM = 1;
    cyc();
    bus.eretM = 0;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [4] = '{5'd12, 5'd13, 5'd14, 5'd9};
    logic [31:0] exps  [4] = '{32'h0040_0000, 32'd0, 32'd0, 32'd0};
    idle();
    resetn = 0;
    bus.syscallM = 1; bus.pcM = 32'h8000_0040;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (flush_exc !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_flush: got %b expected 0", flush_exc);
      end
      cyc();
    end
    resetn = 1;
    bus.syscallM = 0;
    for (int i = 0; i < 4; i++) begin
      bus.cp0_raddrM = addrs[i];
      #1;
      vectors++;
      if (bus.cp0_rdataM !== exps[i]) begin
        miscompares++;
        $display("FAIL reset_read_%0d: got %h expected %h", addrs[i], bus.cp0_rdataM, exps[i]);
      end
    end
    vectors++;
    if (flush_exc !== 1'b0 || status_o !== 32'h0040_0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got flush=%b status=%h expected 0/00400000", flush_exc, status_o);
    end
  endtask

  task automatic test_syscall_ds();
    idle();
    bus.syscallM = 1; bus.pcM = 32'hBFC0_0104; bus.is_in_delayslotM = 1;
    #1;
    vectors++;
    if (flush_exc !== 1'b1 || pc_exc !== 32'hBFC0_0380) begin
      miscompares++;
      $display("FAIL syscall_redirect: got %b/%h expected 1/bfc00380", flush_exc, pc_exc);
    end
    cyc();
    idle();
    #1;
    vectors++;
    if (epc_o !== 32'hBFC0_0100 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd8 || status_o[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL syscall_commit: got epc=%h cause=%h status=%h expected epc=bfc00100 BD=1 code=8 EXL=1",
               epc_o, cause_o, status_o);
    end
  endtask

  task automatic test_eret();
    idle();
    mtc0(5'd14, 32'h8000_1000);
    bus.eretM = 1;
    #1;
    vectors++;
    if (flush_exc !== 1'b1 || pc_exc !== 32'h8000_1000) begin
      miscompares++;
      $display("FAIL eret_redirect: got %b/%h expected 1/80001000", flush_exc, pc_exc);
    end
    cyc();
    idle();
    #1;
    vectors++;
    if (status_o[1] !== 1'b0 || epc_o !== 32'h8000_1000) begin
      miscompares++;
      $display("FAIL eret_commit: got status=%h epc=%h expected EXL=0 epc=80001000", status_o, epc_o);
    end
  endtask

  task automatic test_priority();
    logic [31:0] badv_before, pc, ba;
    idle();
    badv_before = m_badv;
    bus.riM = 1; bus.overflowM = 1; bus.adel_ldM = 1;
    bus.pcM = $urandom() & ~32'd3; bus.bad_addrM = $urandom() | 32'd1;
    cyc();
    idle();
    bus.cp0_raddrM = 5'd8;
    #1;
    vectors++;
    if (cause_o[6:2] !== 5'h0A || bus.cp0_rdataM !== badv_before) begin
      miscompares++;
      $display("FAIL prio_ri: got code=%h badv=%h expected 0a/%h", cause_o[6:2], bus.cp0_rdataM, badv_before);
    end
    do_eret();
    // single address-error flags: check code and BadVAddr source
    for (int k = 0; k < 3; k++) begin
      idle();
      pc = $urandom(); ba = $urandom();
      bus.pcM = pc; bus.bad_addrM = ba;
      bus.adel_ifM = (k == 0); bus.adel_ldM = (k == 1); bus.ades_stM = (k == 2);
      cyc();
      idle();
      bus.cp0_raddrM = 5'd8;
      #1;
      vectors++;
      if (cause_o[6:2] !== ((k == 2) ? 5'h05 : 5'h04) || bus.cp0_rdataM !== ((k == 0) ? pc : ba)) begin
        miscompares++;
        $display("FAIL prio_addr_%0d: got code=%h badv=%h expected %h/%h", k, cause_o[6:2],
                 bus.cp0_rdataM, (k == 2) ? 5'h05 : 5'h04, (k == 0) ? pc : ba);
      end
      do_eret();
    end
  endtask

  task automatic test_timer();
    logic found;
    int waited;
    idle();
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    found = 0;
    waited = 0;
    bus.pcM = 32'h8000_3000;
    while (!found && waited < 120) begin
      #1;
      vectors++;
      if (flush_exc !== m_flush()) begin
        miscompares++;
        $display("FAIL timer_flush_cycle_%0d: got %b expected %b", waited, flush_exc, m_flush());
      end
      found = flush_exc;
      cyc();
      waited++;
    end
    vectors++;
    if (!found || waited < 40) begin
      miscompares++;
      $display("FAIL timer_fire: got fired=%b after %0d cycles expected fire after >=40", found, waited);
    end
    #1;
    vectors++;
    if (cause_o[6:2] !== 5'd0 || cause_o[15] !== 1'b1 || status_o[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL timer_commit: got cause=%h status=%h expected code=0 IP7=1 EXL=1", cause_o, status_o);
    end
    mtc0(5'd11, 32'd100000);
    cyc();
    vectors++;
    if (cause_o[15] !== 1'b0) begin
      miscompares++;
      $display("FAIL timer_ip7_clear: got %b expected 0", cause_o[15]);
    end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_stall_conflict();
    logic [31:0] st, ep, ca;
    idle();
    bus.breakM = 1; bus.stallM = 1; bus.pcM = 32'h8000_2000; bus.cp0_raddrM = 5'd9;
    st = status_o; ep = epc_o; ca = cause_o;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (flush_exc !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_flush_%0d: got %b expected 0", i, flush_exc);
      end
      cyc();
      vectors++;
      if (status_o !== st || epc_o !== ep || cause_o[6:2] !== ca[6:2] || bus.cp0_rdataM !== m_count) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got st=%h epc=%h code=%h count=%h expected %h/%h/%h/%h", i,
                 status_o, epc_o, cause_o[6:2], bus.cp0_rdataM, st, ep, ca[6:2], m_count);
      end
    end
    bus.stallM = 0;
    #1;
    vectors++;
    if (flush_exc !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got %b expected 1", flush_exc);
    end
    cyc();
    idle();
    #1;
    vectors++;
    if (cause_o[6:2] !== 5'd9 || epc_o !== 32'h8000_2000) begin
      miscompares++;
      $display("FAIL stall_commit: got code=%h epc=%h expected 09/80002000", cause_o[6:2], epc_o);
    end
    mtc0(5'd12, 32'd0);
    bus.overflowM = 1; bus.pcM = 32'h8000_4444;
    bus.cp0_wenM = 1; bus.cp0_waddrM = 5'd14; bus.cp0_wdataM = 32'h1234_5678;
    cyc();
    idle();
    #1;
    vectors++;
    if (epc_o !== 32'h8000_4444 || cause_o[6:2] !== 5'h0C) begin
      miscompares++;
      $display("FAIL ov_vs_mtc0: got epc=%h code=%h expected 80004444/0c", epc_o, cause_o[6:2]);
    end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_random();
    logic [4:0] pool [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    for (int i = 0; i < 400; i++) begin
      resetn = ($urandom_range(0, 63) != 0);
      bus.stallM = ($urandom_range(0, 3) == 0);
      bus.pcM = $urandom() & ~32'd3;
      bus.is_in_delayslotM = $urandom_range(0, 1);
      bus.riM = ($urandom_range(0, 9) == 0);
      bus.breakM = ($urandom_range(0, 9) == 0);
      bus.syscallM = ($urandom_range(0, 9) == 0);
      bus.eretM = ($urandom_range(0, 5) == 0);
      bus.overflowM = ($urandom_range(0, 9) == 0);
      bus.adel_ifM = ($urandom_range(0, 11) == 0);
      bus.adel_ldM = ($urandom_range(0, 9) == 0);
      bus.ades_stM = ($urandom_range(0, 9) == 0);
      bus.bad_addrM = $urandom();
      bus.cp0_wenM = ($urandom_range(0, 2) == 0);
      bus.cp0_waddrM = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : pool[$urandom_range(0, 5)];
      bus.cp0_wdataM = $urandom();
      bus.cp0_raddrM = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : pool[$urandom_range(0, 5)];
      ext_int = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      #1;
      vectors++;
      if (flush_exc !== m_flush() || (m_flush() && pc_exc !== m_pc())) begin
        miscompares++;
        $display("FAIL rand_redirect_%0d: got %b/%h expected %b/%h", i, flush_exc, pc_exc, m_flush(), m_pc());
      end
      vectors++;
      if (bus.cp0_rdataM !== m_read(bus.cp0_raddrM)) begin
        miscompares++;
        $display("FAIL rand_read_%0d: reg %0d got %h expected %h", i, bus.cp0_raddrM, bus.cp0_rdataM,
                 m_read(bus.cp0_raddrM));
      end
      cyc();
      vectors++;
      if (status_o !== m_status() || cause_o !== m_cause() || epc_o !== m_epc) begin
        miscompares++;
        $display("FAIL rand_regs_%0d: got %h/%h/%h expected %h/%h/%h", i, status_o, cause_o, epc_o,
                 m_status(), m_cause(), m_epc);
      end
    end
    resetn = 1;
    idle();
  endtask

  initial begin
    resetn = 0;
    bus.pcM = 0;
    idle();
    test_reset();
    test_syscall_ds();
    test_eret();
    test_priority();
    test_timer();
    test_stall_conflict();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_exception.md
Name: cp0_exception

Overview:
- Memory-stage consumer of the decoder's pipelined exception and CP0 control flags: riM, breakM, syscallM, eretM, cp0_wenM and cp0_to_regM.
- Prioritises the exception, updates CP0 state, and drives pipeline flush plus redirect PC.
- Holds the CP0 registers BadVAddr, Count, Compare, Status, Cause and EPC.
- Serves combinational mfc0 reads and implements the Count/Compare timer interrupt.

Parameters:
EXC_ENTRY, 32'hBFC0_0380, handler entry PC for every exception except eret
COUNT_DIV_LOG2, 1, Count increments once every 2^COUNT_DIV_LOG2 cycles

Ports:
clk  in  1  clock, all state updates on its rising edge
resetn  in  1  reset, synchronous, active-low
stallM  in  1  M stage stalled; suppresses commit, CP0 writes and eret
pcM  in  32  PC of the M-stage instruction
is_in_delayslotM  in  1  M-stage instruction sits in a branch delay slot
riM, breakM, syscallM, eretM  in  1 each  decoder flags, M stage
overflowM  in  1  ALU signed overflow
adel_ifM  in  1  fetch address misaligned
adel_ldM, ades_stM  in  1 each  load / store address misaligned
bad_addrM  in  32  data address for load/store address errors
cp0_wenM  in  1  mtc0 commit
cp0_waddrM  in  5  CP0 register number for the write
cp0_wdataM  in  32  write data
cp0_raddrM  in  5  CP0 register number for the mfc0 read
cp0_rdataM  out  32  read data, combinational
ext_int  in  6  hardware interrupt lines, level
flush_exc  out  1  flush F/D/E/M and redirect the PC
pc_exc  out  32  redirect target
epc_o, status_o, cause_o  out  32 each  current register values

Behaviour:
- Reset (resetn=0 at clk edge):
  - Status=32'h0040_0000 (BEV=1, IE=0, EXL=0, IM=0); Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0.
  - Internal divider and timer-interrupt flag TI are cleared.
  - flush_exc=0 while resetn=0.
  - Reset asserted mid-exception discards the pending commit.
- Interrupt pending:
  - int_pend = IE & ~EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
  - Cause.IP[7:2] is refreshed every cycle from {ext_int[5]|TI, ext_int[4:0]}.
  - IP[1:0] are software bits, writable through mtc0.
- Priority, highest first; ExcCode shown in brackets:
  - int [0x00]
  - adel_ifM [0x04]
  - riM [0x0A]
  - breakM [0x09]
  - syscallM [0x08]
  - overflowM [0x0C]
  - adel_ldM [0x04]
  - ades_stM [0x05]
  - eretM (no ExcCode)
- Redirect (combinational, same cycle as the M instruction, gated by ~stallM & resetn):
  - flush_exc=1 on any exception or on eret.
  - pc_exc=EPC for eret, EXC_ENTRY for everything else.
- Commit on the next clk edge after an exception:
  - If EXL=0: EPC = delayslot ? pcM-4 : pcM, and Cause.BD = is_in_delayslotM.
  - If EXL=1: EPC and BD are left unchanged.
  - EXL<=1 and Cause.ExcCode<=code.
  - BadVAddr <= pcM for adel_ifM, bad_addrM for adel_ldM/ades_stM; unchanged for all other codes.
- eret commit: EXL<=0.
- mtc0:
  - Suppressed in any cycle where flush_exc=1, because the exception wins.
  - Otherwise written at the edge.
  - Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Compare and Count all 32 bits. BadVAddr is read-only.
- Timer:
  - Count increments when the divider wraps, modulo 2^32, wrapping 32'hFFFF_FFFF to 0.
  - TI<=1 when Count==Compare and Compare!=0 is not required, i.e. equality alone sets it.
  - A Compare write clears TI in that cycle; a Count write restarts the divider.
  - mtc0 to Count in the same cycle as an increment: the written value wins.
- Read:
  - cp0_rdataM is the current register value for numbers 8, 9, 11, 12, 13 and 14; any other number reads 0.
  - Reads return the pre-edge value, with no same-cycle write bypass.
- Simultaneous events:
  - Multiple flags in one cycle: only the highest-priority flag commits.
  - eret together with another exception flag: the exception wins.
  - stallM=1 holds all exception and eret commits; Count and TI still run.

Decomposition:
- Shared header (defines2.vh) holds:
  - ExcCode constants EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV.
  - CP0 register numbers CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - Status and Cause field bit positions.
- One combinational sub-module, exc_prio: inputs are the flags plus int_pend; outputs are exc_valid, exc_code[4:0] and is_eret.
- Register file and timer stay in cp0_exception.

Test Plan:
- Reset then read: resetn=0 for 2 cycles -> Status=32'h0040_0000; Cause, EPC and Count read 0; flush_exc=0.
- Syscall in delay slot: syscallM=1, pcM=32'hBFC0_0104, is_in_delayslotM=1 -> same cycle flush_exc=1, pc_exc=32'hBFC0_0380; next cycle EPC=32'hBFC0_0100, Cause.BD=1, ExcCode=8, EXL=1.
- eret: with EPC=32'h8000_1000 apply eretM=1 -> flush_exc=1, pc_exc=32'h8000_1000; next cycle EXL=0.
- Priority: riM, overflowM and adel_ldM asserted together -> ExcCode=0x0A; BadVAddr unchanged.
- Timer: mtc0 Status=32'h0000_8001, Compare=20, Count=0 -> ~40 cycles later TI=1 and IP7=1, flush_exc pulses with ExcCode=0; mtc0 Compare then clears IP7.
- Stall and conflict:
  - breakM=1 with stallM=1 for 3 cycles -> no flush and no update; commits on the first unstalled cycle.
  - mtc0 EPC in the same cycle as an overflow -> EPC=pcM, and the mtc0 is discarded.
